// File: rtl/test_rx.sv
// Receive-side test-traffic checker: regenerates the scrambler byte stream per frame,
// compares it with the received bytes and keeps saturating frame/error counters.
module test_rx #(
    parameter bit          SIM        = 1'b0,
    parameter logic [15:0] G_INIT_VAL = 16'h55AA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  mac_rx_data,
    input  logic        mac_rx_valid,
    input  logic        mac_rx_sof,
    input  logic        mac_rx_eof,
    input  logic        clr,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [15:0] frame_len,
    output logic [31:0] frame_cnt,
    output logic [31:0] err_frame_cnt,
    output logic [31:0] byte_err_cnt,
    output logic [15:0] proto_err_cnt,
    output logic        err_sticky
);

    // state | meaning
    // IDLE  | waiting for a start-of-frame byte
    // RX    | inside a frame, comparing bytes against the scrambler
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RX   = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] len_q, len_d;
    logic        ferr_q, ferr_d;
    logic        frame_done_q, frame_done_d;
    logic        frame_ok_q, frame_ok_d;
    logic [15:0] frame_len_q, frame_len_d;
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [31:0] err_frame_cnt_q, err_frame_cnt_d;
    logic [31:0] byte_err_cnt_q, byte_err_cnt_d;
    logic [15:0] proto_err_cnt_q, proto_err_cnt_d;
    logic        err_sticky_q, err_sticky_d;

    logic [15:0] scr_seed;
    logic [15:0] scr_next;
    logic [31:0] scr_word;
    logic [23:0] scr_word_unused;
    logic        sim_unused;
    logic        mism;
    logic [15:0] len_inc;
    logic [1:0]  fr_inc;
    logic [1:0]  efr_inc;
    logic        berr_inc;
    logic        perr_inc;

    // Serial LFSR x^16+x^15+x^13+x^4+1 unrolled 32 bits per word; word bit 0 leaves first.
    function automatic logic [47:0] scr_step(input logic [15:0] s);
        logic [15:0] st;
        logic [31:0] w;
        logic        fb;
        st = s;
        w  = '0;
        for (int i = 0; i < 32; i++) begin
            w[i] = st[15];
            fb   = st[15] ^ st[14] ^ st[12] ^ st[3];
            st   = {st[14:0], fb};
        end
        return {st, w};
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] v, input logic [1:0] inc);
        logic [32:0] s;
        s = {1'b0, v} + {31'b0, inc};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] v, input logic inc);
        logic [16:0] s;
        s = {1'b0, v} + {16'b0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Any SOF reseeds, so the first byte of every frame compares against word 0.
    assign scr_seed                 = mac_rx_sof ? G_INIT_VAL : lfsr_q;
    assign {scr_next, scr_word}     = scr_step(scr_seed);
    assign scr_word_unused          = scr_word[31:8];
    assign sim_unused               = SIM;
    assign mism                     = (mac_rx_data != scr_word[7:0]);
    assign len_inc                  = sat_add16(len_q, 1'b1);

    always_comb begin
        state_d         = state_q;
        lfsr_d          = lfsr_q;
        len_d           = len_q;
        ferr_d          = ferr_q;
        frame_done_d    = 1'b0;
        frame_ok_d      = frame_ok_q;
        frame_len_d     = frame_len_q;
        fr_inc          = 2'd0;
        efr_inc         = 2'd0;
        berr_inc        = 1'b0;
        perr_inc        = 1'b0;

        if (mac_rx_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (mac_rx_sof) begin
                        lfsr_d   = scr_next;
                        berr_inc = mism;
                        if (mac_rx_eof) begin
                            frame_done_d = 1'b1;
                            frame_ok_d   = ~mism;
                            frame_len_d  = 16'd1;
                            fr_inc       = 2'd1;
                            efr_inc      = {1'b0, mism};
                        end else begin
                            len_d   = 16'd1;
                            ferr_d  = mism;
                            state_d = S_RX;
                        end
                    end else begin
                        perr_inc = 1'b1;
                    end
                end
                S_RX: begin
                    lfsr_d   = scr_next;
                    berr_inc = mism;
                    if (mac_rx_sof) begin
                        // Aborted frame is reported as failed; the SOF byte opens a new frame.
                        perr_inc     = 1'b1;
                        frame_done_d = 1'b1;
                        frame_ok_d   = 1'b0;
                        frame_len_d  = len_q;
                        fr_inc       = 2'd1;
                        efr_inc      = 2'd1;
                        if (mac_rx_eof) begin
                            // Both frames end here; the pulse reports the newer one.
                            frame_ok_d  = ~mism;
                            frame_len_d = 16'd1;
                            fr_inc      = 2'd2;
                            efr_inc     = {mism, ~mism};
                            state_d     = S_IDLE;
                        end else begin
                            len_d  = 16'd1;
                            ferr_d = mism;
                        end
                    end else if (mac_rx_eof) begin
                        frame_done_d = 1'b1;
                        frame_ok_d   = ~(ferr_q | mism);
                        frame_len_d  = len_inc;
                        fr_inc       = 2'd1;
                        efr_inc      = {1'b0, ferr_q | mism};
                        state_d      = S_IDLE;
                    end else begin
                        len_d  = len_inc;
                        ferr_d = ferr_q | mism;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        frame_cnt_d     = sat_add32(frame_cnt_q, fr_inc);
        err_frame_cnt_d = sat_add32(err_frame_cnt_q, efr_inc);
        byte_err_cnt_d  = sat_add32(byte_err_cnt_q, {1'b0, berr_inc});
        proto_err_cnt_d = sat_add16(proto_err_cnt_q, perr_inc);
        err_sticky_d    = err_sticky_q | berr_inc | perr_inc;

        // Clear overrides any same-cycle increment; frame tracking keeps running.
        if (clr) begin
            frame_cnt_d     = '0;
            err_frame_cnt_d = '0;
            byte_err_cnt_d  = '0;
            proto_err_cnt_d = '0;
            err_sticky_d    = 1'b0;
            frame_len_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            lfsr_q          <= G_INIT_VAL;
            len_q           <= '0;
            ferr_q          <= 1'b0;
            frame_done_q    <= 1'b0;
            frame_ok_q      <= 1'b0;
            frame_len_q     <= '0;
            frame_cnt_q     <= '0;
            err_frame_cnt_q <= '0;
            byte_err_cnt_q  <= '0;
            proto_err_cnt_q <= '0;
            err_sticky_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            lfsr_q          <= lfsr_d;
            len_q           <= len_d;
            ferr_q          <= ferr_d;
            frame_done_q    <= frame_done_d;
            frame_ok_q      <= frame_ok_d;
            frame_len_q     <= frame_len_d;
            frame_cnt_q     <= frame_cnt_d;
            err_frame_cnt_q <= err_frame_cnt_d;
            byte_err_cnt_q  <= byte_err_cnt_d;
            proto_err_cnt_q <= proto_err_cnt_d;
            err_sticky_q    <= err_sticky_d;
        end
    end

    assign frame_done    = frame_done_q;
    assign frame_ok      = frame_ok_q;
    assign frame_len     = frame_len_q;
    assign frame_cnt     = frame_cnt_q;
    assign err_frame_cnt = err_frame_cnt_q;
    assign byte_err_cnt  = byte_err_cnt_q;
    assign proto_err_cnt = proto_err_cnt_q;
    assign err_sticky    = err_sticky_q;

endmodule

// File: tb/tb_test_rx.sv
// Scoreboard bench for test_rx: frame results are queued at issue time and checked
// by an independent monitor on each frame_done; counters are checked at quiet points.
module tb_test_rx;

    localparam logic [15:0] SEED = 16'h55AA;

    logic        clk;
    logic        rst;
    logic [7:0]  mac_rx_data;
    logic        mac_rx_valid;
    logic        mac_rx_sof;
    logic        mac_rx_eof;
    logic        clr;
    logic        frame_done;
    logic        frame_ok;
    logic [15:0] frame_len;
    logic [31:0] frame_cnt;
    logic [31:0] err_frame_cnt;
    logic [31:0] byte_err_cnt;
    logic [15:0] proto_err_cnt;
    logic        err_sticky;

    test_rx #(.SIM(1'b1), .G_INIT_VAL(SEED)) dut (
        .clk(clk), .rst(rst),
        .mac_rx_data(mac_rx_data), .mac_rx_valid(mac_rx_valid),
        .mac_rx_sof(mac_rx_sof), .mac_rx_eof(mac_rx_eof), .clr(clr),
        .frame_done(frame_done), .frame_ok(frame_ok), .frame_len(frame_len),
        .frame_cnt(frame_cnt), .err_frame_cnt(err_frame_cnt),
        .byte_err_cnt(byte_err_cnt), .proto_err_cnt(proto_err_cnt),
        .err_sticky(err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        ok;
        logic [15:0] len;
    } res_t;

    res_t        exp_q[$];
    res_t        mon_e;
    int          total = 0;
    int          bad = 0;
    logic [15:0] m_s;
    logic [31:0] exp_frames, exp_err_frames, exp_berr;
    logic [15:0] exp_proto;
    logic        exp_sticky;

    // Reference scrambler: 16-bit Fibonacci LFSR, taps 16/15/13/4, 32 output bits per word.
    function automatic logic [7:0] m_next_byte();
        logic [31:0] w;
        logic        fb;
        w = '0;
        for (int i = 0; i < 32; i++) begin
            w[i] = m_s[15];
            fb   = m_s[15] ^ m_s[14] ^ m_s[12] ^ m_s[3];
            m_s  = {m_s[14:0], fb};
        end
        return w[7:0];
    endfunction

    function automatic logic [31:0] sat32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_frame_cnt"}, frame_cnt, exp_frames);
        check({tag, "_err_frame_cnt"}, err_frame_cnt, exp_err_frames);
        check({tag, "_byte_err_cnt"}, byte_err_cnt, exp_berr);
        check({tag, "_proto_err_cnt"}, {16'b0, proto_err_cnt}, {16'b0, exp_proto});
        check({tag, "_err_sticky"}, {31'b0, err_sticky}, {31'b0, exp_sticky});
    endtask

    task automatic send_byte(input logic [7:0] d, input bit s, input bit e, input bit c);
        mac_rx_data  = d;
        mac_rx_valid = 1'b1;
        mac_rx_sof   = s;
        mac_rx_eof   = e;
        clr          = c;
        @(posedge clk);
        #1;
        mac_rx_valid = 1'b0;
        mac_rx_sof   = 1'b0;
        mac_rx_eof   = 1'b0;
        clr          = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // e1 flips bit 0, e2 flips bit 7 of the indexed byte; -1 disables.
    task automatic send_frame(input int n, input bit gaps, input int e1, input int e2);
        logic [7:0] b;
        res_t       r;
        bit         bad_f;
        bad_f = (e1 >= 0 && e1 < n) || (e2 >= 0 && e2 < n);
        r.ok  = ~bad_f;
        r.len = 16'(n);
        exp_q.push_back(r);
        m_s = SEED;
        for (int k = 0; k < n; k++) begin
            b = m_next_byte();
            if (k == e1) b = b ^ 8'h01;
            if (k == e2) b = b ^ 8'h80;
            if (k == e1 || k == e2) begin
                exp_berr   = sat32(exp_berr);
                exp_sticky = 1'b1;
            end
            if (gaps && k > 0) idle($urandom_range(0, 3));
            send_byte(b, k == 0, k == n - 1, 1'b0);
        end
        exp_frames = sat32(exp_frames);
        if (bad_f) exp_err_frames = sat32(exp_err_frames);
    endtask

    task automatic reset_expect();
        exp_frames     = '0;
        exp_err_frames = '0;
        exp_berr       = '0;
        exp_proto      = '0;
        exp_sticky     = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst && frame_done) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_frame_done: got ok=%0b len=%0d expected no pulse",
                         frame_ok, frame_len);
            end else begin
                mon_e = exp_q.pop_front();
                if (frame_ok !== mon_e.ok || frame_len !== mon_e.len) begin
                    bad++;
                    $display("FAIL frame_result: got ok=%0b len=%0d expected ok=%0b len=%0d",
                             frame_ok, frame_len, mon_e.ok, mon_e.len);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        res_t       r;
        rst          = 1'b0;
        mac_rx_data  = 8'h00;
        mac_rx_valid = 1'b0;
        mac_rx_sof   = 1'b0;
        mac_rx_eof   = 1'b0;
        clr          = 1'b0;
        reset_expect();
        idle(3);
        check("rst_frame_done", {31'b0, frame_done}, 32'd0);
        check("rst_frame_ok", {31'b0, frame_ok}, 32'd0);
        check("rst_frame_len", {16'b0, frame_len}, 32'd0);
        check_counters("rst");
        @(negedge clk);
        rst = 1'b1;
        idle(1);

        // Three clean 64-byte frames with 2-cycle gaps
        for (int f = 0; f < 3; f++) begin
            send_frame(64, 1'b0, -1, -1);
            idle(2);
        end
        idle(2);
        check_counters("t1");
        check("t1_frame_len", {16'b0, frame_len}, 32'd64);

        // Two corrupted bytes, then a clean frame
        send_frame(16, 1'b0, 5, 9);
        idle(3);
        check_counters("t2");
        send_frame(16, 1'b0, -1, -1);
        idle(3);
        check_counters("t2b");

        // Gapped frame, single-byte frame, back-to-back frames
        send_frame(100, 1'b1, -1, -1);
        idle(3);
        check("t3_len100", {16'b0, frame_len}, 32'd100);
        send_frame(1, 1'b0, -1, -1);
        idle(2);
        check("t3_len1", {16'b0, frame_len}, 32'd1);
        send_frame(20, 1'b0, -1, -1);
        send_frame(7, 1'b0, -1, -1);
        send_frame(33, 1'b0, -1, -1);
        idle(3);
        check("t3_len33", {16'b0, frame_len}, 32'd33);
        check_counters("t3");

        // Stray byte in IDLE, then SOF after byte 4 of a frame
        send_byte(8'h33, 1'b0, 1'b0, 1'b0);
        exp_proto  = exp_proto + 16'd1;
        exp_sticky = 1'b1;
        r.ok  = 1'b0;
        r.len = 16'd4;
        exp_q.push_back(r);
        m_s = SEED;
        for (int k = 0; k < 4; k++) begin
            b = m_next_byte();
            send_byte(b, k == 0, 1'b0, 1'b0);
        end
        exp_proto      = exp_proto + 16'd1;
        exp_frames     = sat32(exp_frames);
        exp_err_frames = sat32(exp_err_frames);
        send_frame(6, 1'b0, -1, -1);
        idle(3);
        check("t4_proto2", {16'b0, proto_err_cnt}, 32'd2);
        check("t4_len6", {16'b0, frame_len}, 32'd6);
        check_counters("t4");

        // Byte-error counter saturation
        @(negedge clk);
        force dut.byte_err_cnt_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.byte_err_cnt_q;
        @(posedge clk);
        #1;
        exp_berr = 32'hFFFF_FFFE;
        send_frame(16, 1'b0, 3, 7);
        idle(3);
        check("t5_sat", byte_err_cnt, 32'hFFFF_FFFF);

        // clr in the same cycle as a mismatch: clr wins, frame still fails
        r.ok  = 1'b0;
        r.len = 16'd4;
        exp_q.push_back(r);
        m_s = SEED;
        for (int k = 0; k < 4; k++) begin
            b = m_next_byte();
            if (k == 2) b = b ^ 8'h10;
            send_byte(b, k == 0, k == 3, k == 2);
        end
        reset_expect();
        exp_frames     = 32'd1;
        exp_err_frames = 32'd1;
        idle(3);
        check("t5_clr_berr", byte_err_cnt, 32'd0);
        check("t5_clr_len", {16'b0, frame_len}, 32'd4);
        check_counters("t5");

        // Asynchronous reset mid-frame
        m_s = SEED;
        for (int k = 0; k < 5; k++) begin
            b = m_next_byte();
            send_byte(b, k == 0, 1'b0, 1'b0);
        end
        #3;
        rst = 1'b0;
        #1;
        reset_expect();
        check("t6_done", {31'b0, frame_done}, 32'd0);
        check("t6_ok", {31'b0, frame_ok}, 32'd0);
        check("t6_len", {16'b0, frame_len}, 32'd0);
        check_counters("t6");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle(1);
        send_frame(12, 1'b0, -1, -1);
        idle(3);
        check("t6_len12", {16'b0, frame_len}, 32'd12);
        check_counters("t6b");

        idle(2);
        check("pending_results", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
